// File: rtl/bp_update_scheduler.sv
// Predictor training update scheduler: queues BHT/BTB updates from branch
// resolution and issues them in program order over independent req/gnt ports.
module bp_update_scheduler #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned VLEN  = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             debug_mode_i,
  input  logic             flush_bp_i,
  input  logic             res_valid_i,
  input  logic [VLEN-1:0]  res_pc_i,
  input  logic [VLEN-1:0]  res_target_i,
  input  logic             res_taken_i,
  input  logic             res_conditional_i,
  input  logic             res_to_reg_i,
  output logic             bht_req_o,
  input  logic             bht_gnt_i,
  output logic [VLEN-1:0]  bht_pc_o,
  output logic             bht_taken_o,
  output logic             btb_req_o,
  input  logic             btb_gnt_i,
  output logic [VLEN-1:0]  btb_pc_o,
  output logic [VLEN-1:0]  btb_target_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] target;
    logic            taken;
    logic            need_bht;
    logic            need_btb;
  } entry_t;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_e;

  entry_t           mem_q [DEPTH];
  entry_t           head;
  entry_t           wr_entry;
  logic [PTR_W:0]   rd_ptr_q, wr_ptr_q;
  logic [PTR_W-1:0] rd_idx, wr_idx;
  logic [CNT_W-1:0] drop_cnt_q;
  state_e           state_q, state_d;

  logic empty, full, last_entry;
  logic issuing, bht_done, btb_done;
  logic push, pop, do_write, drop;

  // Pointer extra bit separates full (MSBs differ) from empty (all equal).
  assign rd_idx     = rd_ptr_q[PTR_W-1:0];
  assign wr_idx     = wr_ptr_q[PTR_W-1:0];
  assign empty      = (rd_ptr_q == wr_ptr_q);
  assign full       = (rd_ptr_q[PTR_W] != wr_ptr_q[PTR_W]) && (rd_idx == wr_idx);
  assign last_entry = ((wr_ptr_q - rd_ptr_q) == PTR_ONE);

  assign head    = mem_q[rd_idx];
  assign issuing = (state_q == ISSUE);

  // A port is finished when its flag was already cleared or it is granted now.
  assign bht_done = !head.need_bht || bht_gnt_i;
  assign btb_done = !head.need_btb || btb_gnt_i;
  assign pop      = issuing && bht_done && btb_done;

  assign push = res_valid_i && (res_conditional_i || res_to_reg_i)
             && !debug_mode_i && !flush_bp_i;
  // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
  assign do_write = push && (!full || pop);
  assign drop     = push && full && !pop;

  assign wr_entry = '{
    pc:       res_pc_i,
    target:   res_target_i,
    taken:    res_taken_i,
    need_bht: res_conditional_i,
    need_btb: res_to_reg_i
  };

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (flush_bp_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (pop)      rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (do_write) wr_ptr_q <= wr_ptr_q + PTR_ONE;
    end
  end

  // NOTE: the storage array has no reset; every read is qualified by the
  // pointers/FSM, so stale contents are never observable and the array can
  // map onto plain flops or a register file.
  always_ff @(posedge clk_i) begin
    if (issuing && !pop) begin
      if (bht_gnt_i) mem_q[rd_idx].need_bht <= 1'b0;
      if (btb_gnt_i) mem_q[rd_idx].need_btb <= 1'b0;
    end
    if (do_write) mem_q[wr_idx] <= wr_entry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (do_write) state_d = ISSUE;
      ISSUE:   if (pop && last_entry && !do_write) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_bp_i) state_d = IDLE;
  end

  // Outputs are held at zero while idle so no stale storage leaks out.
  always_comb begin
    bht_req_o    = 1'b0;
    bht_pc_o     = '0;
    bht_taken_o  = 1'b0;
    btb_req_o    = 1'b0;
    btb_pc_o     = '0;
    btb_target_o = '0;
    if (issuing) begin
      bht_req_o    = head.need_bht;
      bht_pc_o     = head.pc;
      bht_taken_o  = head.taken;
      btb_req_o    = head.need_btb;
      btb_pc_o     = head.pc;
      btb_target_o = head.target;
    end
  end

  assign busy_o     = !empty;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Scoreboard bench for bp_update_scheduler: stimulus queues expected updates,
// a negedge monitor pops and compares on every req&gnt transfer.
module tb_bp_update_scheduler;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int VLEN  = 32;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             debug_mode_i = 1'b0;
  logic             flush_bp_i = 1'b0;
  logic             res_valid_i = 1'b0;
  logic [VLEN-1:0]  res_pc_i = '0;
  logic [VLEN-1:0]  res_target_i = '0;
  logic             res_taken_i = 1'b0;
  logic             res_conditional_i = 1'b0;
  logic             res_to_reg_i = 1'b0;
  logic             bht_req_o;
  logic             bht_gnt_i = 1'b0;
  logic [VLEN-1:0]  bht_pc_o;
  logic             bht_taken_o;
  logic             btb_req_o;
  logic             btb_gnt_i = 1'b0;
  logic [VLEN-1:0]  btb_pc_o;
  logic [VLEN-1:0]  btb_target_o;
  logic             busy_o;
  logic [CNT_W-1:0] drop_cnt_o;

  bp_update_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W), .VLEN(VLEN)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .debug_mode_i      (debug_mode_i),
    .flush_bp_i        (flush_bp_i),
    .res_valid_i       (res_valid_i),
    .res_pc_i          (res_pc_i),
    .res_target_i      (res_target_i),
    .res_taken_i       (res_taken_i),
    .res_conditional_i (res_conditional_i),
    .res_to_reg_i      (res_to_reg_i),
    .bht_req_o         (bht_req_o),
    .bht_gnt_i         (bht_gnt_i),
    .bht_pc_o          (bht_pc_o),
    .bht_taken_o       (bht_taken_o),
    .btb_req_o         (btb_req_o),
    .btb_gnt_i         (btb_gnt_i),
    .btb_pc_o          (btb_pc_o),
    .btb_target_o      (btb_target_o),
    .busy_o            (busy_o),
    .drop_cnt_o        (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef enum {GNT_HOLD, GNT_DELAY} gnt_mode_e;

  exp_t      bht_q[$];
  exp_t      btb_q[$];
  exp_t      mon_e;
  int        n_cmp = 0;
  int        n_err = 0;
  int        exp_drop = 0;
  gnt_mode_e gnt_mode = GNT_HOLD;
  int        bht_delay = 0, btb_delay = 0;
  int        bht_wait = 0, btb_wait = 0;
  logic      bht_xfer = 1'b0, btb_xfer = 1'b0;
  logic [5:0] bht_seq, btb_seq;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a req&gnt seen at the negedge is a transfer at the next posedge.
  always @(negedge clk_i) begin
    bht_xfer = rst_ni && bht_req_o && bht_gnt_i;
    btb_xfer = rst_ni && btb_req_o && btb_gnt_i;
    if (bht_xfer) begin
      if (bht_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL bht_unexpected: got update pc 0x%0h, expected none", bht_pc_o);
      end else begin
        mon_e = bht_q.pop_front();
        check("bht_pc", 64'(bht_pc_o), 64'(mon_e.pc));
        check("bht_taken", 64'(bht_taken_o), 64'(mon_e.data));
      end
    end
    if (btb_xfer) begin
      if (btb_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL btb_unexpected: got update pc 0x%0h, expected none", btb_pc_o);
      end else begin
        mon_e = btb_q.pop_front();
        check("btb_pc", 64'(btb_pc_o), 64'(mon_e.pc));
        check("btb_target", 64'(btb_target_o), 64'(mon_e.data));
      end
    end
  end

  // Frontend model: grants after a per-port number of req cycles, or never.
  always @(posedge clk_i) begin
    #2;
    if (bht_xfer) bht_wait = 0;
    if (btb_xfer) btb_wait = 0;
    if (gnt_mode == GNT_HOLD) begin
      bht_gnt_i = 1'b0;
      btb_gnt_i = 1'b0;
    end else begin
      if (bht_delay == 0) bht_gnt_i = 1'b1;
      else if (bht_req_o) begin
        bht_gnt_i = (bht_wait >= bht_delay);
        bht_wait++;
      end else bht_gnt_i = 1'b0;
      if (btb_delay == 0) btb_gnt_i = 1'b1;
      else if (btb_req_o) begin
        btb_gnt_i = (btb_wait >= btb_delay);
        btb_wait++;
      end else btb_gnt_i = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_gnt(input gnt_mode_e mode, input int bd, input int td);
    gnt_mode  = mode;
    bht_delay = bd;
    btb_delay = td;
    bht_wait  = 0;
    btb_wait  = 0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] target, input logic taken,
                      input logic cond, input logic to_reg, input bit accept);
    exp_t e;
    res_valid_i       = 1'b1;
    res_pc_i          = pc;
    res_target_i      = target;
    res_taken_i       = taken;
    res_conditional_i = cond;
    res_to_reg_i      = to_reg;
    if (accept) begin
      e.pc = pc;
      if (cond) begin e.data = 32'(taken); bht_q.push_back(e); end
      if (to_reg) begin e.data = target; btb_q.push_back(e); end
    end
    tick();
    res_valid_i       = 1'b0;
    res_conditional_i = 1'b0;
    res_to_reg_i      = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int n = 0;
    while (busy_o && n < max_cycles) begin
      tick();
      n++;
    end
    check(name, 64'(busy_o), 64'h0);
  endtask

  task automatic sample_reqs(input int cycles);
    bht_seq = '0;
    btb_seq = '0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_i);
      bht_seq[i] = bht_req_o;
      btb_seq[i] = btb_req_o;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick(); tick();
    check("rst_bht_req", 64'(bht_req_o), 64'h0);
    check("rst_btb_req", 64'(btb_req_o), 64'h0);
    check("rst_busy", 64'(busy_o), 64'h0);
    check("rst_drop_cnt", 64'(drop_cnt_o), 64'h0);
    check("rst_bht_pc", 64'(bht_pc_o), 64'h0);
    check("rst_btb_target", 64'(btb_target_o), 64'h0);
    rst_ni = 1'b1;
    tick();

    // 1: single conditional update, grants tied high
    set_gnt(GNT_DELAY, 0, 0);
    push(32'h8000_0010, 32'h8000_0100, 1'b1, 1'b1, 1'b0, 1'b1);
    sample_reqs(5);
    check("t1_bht_req_seq", 64'(bht_seq), 64'h01);
    check("t1_btb_req_seq", 64'(btb_seq), 64'h00);
    tick();

    // 2: both ports, BHT granted after 3 req cycles, BTB after 1
    set_gnt(GNT_DELAY, 3, 1);
    push(32'h8000_0200, 32'h8000_0400, 1'b0, 1'b1, 1'b1, 1'b1);
    sample_reqs(6);
    check("t2_bht_req_seq", 64'(bht_seq), 64'h0F);
    check("t2_btb_req_seq", 64'(btb_seq), 64'h03);
    check("t2_busy_after", 64'(busy_o), 64'h0);
    tick();

    // 3: DEPTH+2 pushes with grants held, then in-order drain
    set_gnt(GNT_HOLD, 0, 0);
    for (int i = 0; i < DEPTH + 2; i++)
      push(32'h0000_1000 + 32'(4 * i), 32'h0, 1'(i), 1'b1, 1'b0, i < DEPTH);
    exp_drop = 2;
    check("t3_busy", 64'(busy_o), 64'h1);
    check("t3_drop_cnt", 64'(drop_cnt_o), 64'(exp_drop));
    check("t3_head_req", 64'(bht_req_o), 64'h1);
    check("t3_head_pc", 64'(bht_pc_o), 64'h1000);
    set_gnt(GNT_DELAY, 0, 0);
    wait_idle("t3_drain_idle", 20);
    check("t3_bht_all_seen", 64'(bht_q.size()), 64'h0);

    // 4: full FIFO, pop and push in the same cycle
    set_gnt(GNT_HOLD, 0, 0);
    tick();
    for (int i = 0; i < DEPTH; i++)
      push(32'h0000_2000 + 32'(4 * i), 32'h0000_9000 + 32'(16 * i), 1'b0, 1'b0, 1'b1, 1'b1);
    set_gnt(GNT_DELAY, 0, 0);
    push(32'h0000_2010, 32'h0000_9040, 1'b0, 1'b0, 1'b1, 1'b1);
    set_gnt(GNT_HOLD, 0, 0);
    check("t4_no_drop", 64'(drop_cnt_o), 64'(exp_drop));
    check("t4_busy", 64'(busy_o), 64'h1);
    push(32'h0000_2014, 32'h0000_9050, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_drop = 3;
    check("t4_still_full", 64'(drop_cnt_o), 64'(exp_drop));
    set_gnt(GNT_DELAY, 0, 0);
    wait_idle("t4_drain_idle", 20);
    check("t4_btb_all_seen", 64'(btb_q.size()), 64'h0);

    // 5: flush with 3 queued entries and a same-cycle push
    set_gnt(GNT_HOLD, 0, 0);
    tick();
    push(32'h0000_3000, 32'h0000_9100, 1'b1, 1'b1, 1'b0, 1'b1);
    push(32'h0000_3004, 32'h0000_9104, 1'b0, 1'b0, 1'b1, 1'b1);
    push(32'h0000_3008, 32'h0000_9108, 1'b1, 1'b1, 1'b1, 1'b1);
    flush_bp_i = 1'b1;
    push(32'h0000_300C, 32'h0000_910C, 1'b1, 1'b1, 1'b0, 1'b0);
    flush_bp_i = 1'b0;
    bht_q.delete();
    btb_q.delete();
    check("t5_bht_req", 64'(bht_req_o), 64'h0);
    check("t5_btb_req", 64'(btb_req_o), 64'h0);
    check("t5_busy", 64'(busy_o), 64'h0);
    check("t5_drop_cnt", 64'(drop_cnt_o), 64'(exp_drop));
    set_gnt(GNT_DELAY, 0, 0);
    tick(); tick(); tick();
    check("t5_stays_idle", 64'(busy_o), 64'h0);

    // 6a: debug mode still drains queued entries
    set_gnt(GNT_HOLD, 0, 0);
    push(32'h0000_5000, 32'h0000_9200, 1'b1, 1'b1, 1'b1, 1'b1);
    debug_mode_i = 1'b1;
    set_gnt(GNT_DELAY, 0, 0);
    wait_idle("t6_debug_drain", 20);

    // 6b: reset mid-handshake with debug mode set
    debug_mode_i = 1'b0;
    set_gnt(GNT_HOLD, 0, 0);
    push(32'h0000_4000, 32'h0000_9300, 1'b1, 1'b1, 1'b0, 1'b1);
    debug_mode_i = 1'b1;
    @(negedge clk_i);
    check("t6_req_before_rst", 64'(bht_req_o), 64'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    bht_q.delete();
    btb_q.delete();
    exp_drop = 0;
    check("t6_rst_bht_req", 64'(bht_req_o), 64'h0);
    check("t6_rst_bht_pc", 64'(bht_pc_o), 64'h0);
    check("t6_rst_busy", 64'(busy_o), 64'h0);
    check("t6_rst_drop_cnt", 64'(drop_cnt_o), 64'(exp_drop));
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    push(32'h0000_4100, 32'h0000_9400, 1'b1, 1'b1, 1'b0, 1'b0);
    push(32'h0000_4104, 32'h0000_9404, 1'b0, 1'b0, 1'b1, 1'b0);
    sample_reqs(3);
    check("t6_debug_no_bht", 64'(bht_seq), 64'h0);
    check("t6_debug_no_btb", 64'(btb_seq), 64'h0);
    check("t6_debug_busy", 64'(busy_o), 64'h0);
    tick();
    debug_mode_i = 1'b0;
    push(32'h0000_6000, 32'h0000_9500, 1'b1, 1'b1, 1'b1, 1'b1);
    set_gnt(GNT_DELAY, 0, 0);
    wait_idle("t6_final_drain", 20);
    tick();
    check("end_bht_all_seen", 64'(bht_q.size()), 64'h0);
    check("end_btb_all_seen", 64'(btb_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
